// File: rtl/sha256_uart_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sha256_uart_host
// Brief    : Frames a message (0x01, payload, 0xFF) into a UART TX core and
//            packs the 64-char ASCII hex digest returned by a UART RX core.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_uart_host #(
    parameter int TIMEOUT_CYCLES = 27_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    input  logic         tx_busy,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [255:0] digest,
    output logic         done,
    output logic         err_hex,
    output logic         err_ff,
    output logic         err_timeout
);

    localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_SOF  = 3'd1,
        S_SEND_PAY  = 3'd2,
        S_DRAIN     = 3'd3,
        S_SEND_EOF  = 3'd4,
        S_WAIT_RESP = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  r_guard;
    logic                  r_eof_sent;
    logic [c_IDLE_W-1:0]   r_idle;
    logic [6:0]            r_cnt;
    logic [255:0]          r_digest;
    logic                  r_err_hex;
    logic                  r_err_ff;
    logic                  r_err_timeout;

    logic                  w_launch_ok;
    logic                  w_tx_go;
    logic [7:0]            w_tx_byte;
    logic                  w_set_ff;
    logic                  w_timeout;
    logic                  w_is_hex;
    logic [3:0]            w_nibble;

    // guard keeps the TX core's busy flag time to rise before the next launch
    assign w_launch_ok = !tx_busy && !r_tx_start && !r_guard;
    assign w_timeout   = (r_idle == c_IDLE_MAX);

    always_comb begin
        w_is_hex = 1'b1;
        w_nibble = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_nibble = rx_data[3:0];
        end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                     (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            w_nibble = rx_data[3:0] + 4'd9;
        end else begin
            w_is_hex = 1'b0;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_tx_go   = 1'b0;
        w_tx_byte = 8'h00;
        w_set_ff  = 1'b0;
        in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SEND_SOF;
            end
            S_SEND_SOF: begin
                if (w_launch_ok) begin
                    w_tx_go   = 1'b1;
                    w_tx_byte = 8'h01;
                    w_next    = S_SEND_PAY;
                end
            end
            S_SEND_PAY: begin
                in_ready = w_launch_ok;
                if (in_valid && w_launch_ok) begin
                    w_tx_go   = 1'b1;
                    w_tx_byte = in_data;
                    // an embedded 0xFF already terminates the frame on the wire
                    if (in_data == 8'hFF) begin
                        w_set_ff = 1'b1;
                        w_next   = in_last ? S_WAIT_RESP : S_DRAIN;
                    end else if (in_last) begin
                        w_next = S_SEND_EOF;
                    end
                end
            end
            S_DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_next = S_WAIT_RESP;
            end
            S_SEND_EOF: begin
                if (!r_eof_sent && w_launch_ok) begin
                    w_tx_go   = 1'b1;
                    w_tx_byte = 8'hFF;
                end else if (r_eof_sent && r_guard) begin
                    w_next = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (rx_valid) begin
                    if (r_cnt == 7'd63) w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_guard       <= 1'b0;
            r_eof_sent    <= 1'b0;
            r_idle        <= '0;
            r_cnt         <= 7'd0;
            r_digest      <= 256'd0;
            r_err_hex     <= 1'b0;
            r_err_ff      <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= w_tx_go;
            r_guard    <= r_tx_start;
            if (w_tx_go) r_tx_data <= w_tx_byte;
            if (w_set_ff) r_err_ff <= 1'b1;
            if (r_state == S_SEND_EOF && w_tx_go) r_eof_sent <= 1'b1;

            if (r_state == S_IDLE && start) begin
                r_digest      <= 256'd0;
                r_err_hex     <= 1'b0;
                r_err_ff      <= 1'b0;
                r_err_timeout <= 1'b0;
                r_cnt         <= 7'd0;
                r_eof_sent    <= 1'b0;
            end

            if (r_state == S_WAIT_RESP) begin
                if (rx_valid) begin
                    r_digest <= {r_digest[251:0], w_nibble};
                    r_cnt    <= r_cnt + 7'd1;
                    r_idle   <= '0;
                    if (!w_is_hex) r_err_hex <= 1'b1;
                end else if (w_timeout) begin
                    r_err_timeout <= 1'b1;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end else begin
                r_idle <= '0;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign digest      = r_digest;
    assign err_hex     = r_err_hex;
    assign err_ff      = r_err_ff;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sha256_uart_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sha256_uart_host
// Brief    : Scoreboard bench for sha256_uart_host with a simple UART TX model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_uart_host;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [255:0] digest;
    logic         done;
    logic         err_hex;
    logic         err_ff;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] dig;
        logic         eh;
        logic         ef;
        logic         et;
    } job_t;

    logic [7:0] exp_tx[$];
    job_t       exp_job[$];
    logic [7:0] pay_q[$];

    string abc_lo = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
    string abc_up = "BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD";
    string abc_g  = "bag816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
    string part10 = "ba7816bf8f";
    localparam logic [255:0] c_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_ABCG = 256'hba0816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    sha256_uart_host #(.TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .digest      (digest),
        .done        (done),
        .err_hex     (err_hex),
        .err_ff      (err_ff),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_job(input logic [255:0] d, input logic eh, input logic ef, input logic et);
        job_t j;
        j.dig = d; j.eh = eh; j.ef = ef; j.et = et;
        exp_job.push_back(j);
    endtask

    // TX core model and TX scoreboard
    initial begin : tx_mon
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                chk("tx_while_busy", tx_busy, 1'b0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    chk("tx_byte", tx_data, exp_tx.pop_front());
                end
                busy_cnt = 6;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = (busy_cnt != 0);
        end
    end

    // job-completion scoreboard
    initial begin : job_mon
        job_t j;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_job.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done=1 expected done=0");
                end else begin
                    j = exp_job.pop_front();
                    chk("digest", digest, j.dig);
                    chk("err_flags", {err_hex, err_ff, err_timeout}, {j.eh, j.ef, j.et});
                end
            end
        end
    end

    task automatic start_job();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_payload(input bit with_last);
        for (int i = 0; i < pay_q.size(); i++) begin
            bit ok;
            ok = 1'b0;
            in_data  = pay_q[i];
            in_valid = 1'b1;
            in_last  = with_last && (i == pay_q.size() - 1);
            for (int k = 0; k < 200; k++) begin
                @(negedge clk); #1;
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 expected 1 for byte %0d", i);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_tx_drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            if (exp_tx.size() == 0) begin
                ok = 1'b0 | 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tx_drain: got %0d pending bytes expected 0", exp_tx.size());
            exp_tx.delete();
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic send_resp(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (i != 0) repeat (gap) @(posedge clk);
            #1;
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (exp_job.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending jobs expected 0", exp_job.size());
            exp_job.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run_abc(input string resp, input logic [255:0] d, input logic eh);
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h61); exp_tx.push_back(8'h62);
        exp_tx.push_back(8'h63); exp_tx.push_back(8'hFF);
        push_job(d, eh, 1'b0, 1'b0);
        start_job();
        pay_q = '{8'h61, 8'h62, 8'h63};
        send_payload(1'b1);
        wait_tx_drain();
        send_resp(resp, 1);
        wait_done();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ctrl", {in_ready, tx_start, done}, 3'b000);
        chk("rst_digest", digest, 256'd0);
        chk("rst_errs", {err_hex, err_ff, err_timeout}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_abc(abc_lo, c_ABC, 1'b0);
        run_abc(abc_up, c_ABC, 1'b0);
        run_abc(abc_g, c_ABCG, 1'b1);

        // embedded 0xFF terminates the frame, trailing byte drained
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h41); exp_tx.push_back(8'hFF);
        push_job(c_ABC, 1'b0, 1'b1, 1'b0);
        start_job();
        pay_q = '{8'h41, 8'hFF, 8'h42};
        send_payload(1'b1);
        wait_tx_drain();
        send_resp(abc_lo, 1);
        wait_done();

        // response timeout: 98-cycle gaps survive, then silence
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h61); exp_tx.push_back(8'hFF);
        push_job(256'hba7816bf8f, 1'b0, 1'b0, 1'b1);
        start_job();
        pay_q = '{8'h61};
        send_payload(1'b1);
        wait_tx_drain();
        send_resp(part10, 98);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            n++;
        end
        chk("timeout_latency", n, 100);
        wait_done();

        // asynchronous reset in the middle of the payload
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h61);
        start_job();
        pay_q = '{8'h61};
        send_payload(1'b0);
        wait_tx_drain();
        chk("busy_mid_job", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_ctrl", {in_ready, tx_start, done}, 3'b000);
        chk("arst_digest", digest, 256'd0);
        chk("arst_errs", {err_hex, err_ff, err_timeout}, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        run_abc(abc_lo, c_ABC, 1'b0);

        repeat (20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
